// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default geometry plus Gray/binary conversions
// used by both the read-side and write-side pointer blocks.
package fifo_pkg;

   localparam int FIFO_ADDR_WIDTH = 3;
   localparam int FIFO_PTR_WIDTH  = FIFO_ADDR_WIDTH + 1;
   localparam int FIFO_DEPTH      = 2 ** FIFO_ADDR_WIDTH;

   function automatic logic [31:0] bin2gray(input logic [31:0] bin);
      return bin ^ (bin >> 1);
   endfunction

   // XOR prefix from the MSB down; unused upper bits are zero and fall out harmlessly.
   function automatic logic [31:0] gray2bin(input logic [31:0] gray);
      logic [31:0] bin;
      bin[31] = gray[31];
      for (int i = 30; i >= 0; i--) begin
         bin[i] = bin[i+1] ^ gray[i];
      end
      return bin;
   endfunction

endpackage

// File: rtl/rptr_empty_if.sv
// Read-side FIFO bus: read request and foreign write pointer in, read pointer and status out.
interface rptr_empty_if #(parameter int ADDR_WIDTH = fifo_pkg::FIFO_ADDR_WIDTH);

   logic                  rinc;
   logic [ADDR_WIDTH:0]   wptr_async;
   logic [ADDR_WIDTH:0]   rptr;
   logic [ADDR_WIDTH-1:0] raddr;
   logic                  empty;
   logic                  almost_empty;
   logic [ADDR_WIDTH:0]   rlevel;
   logic                  underflow;

   modport master (
      output rinc, wptr_async,
      input  rptr, raddr, empty, almost_empty, rlevel, underflow
   );

   modport slave (
      input  rinc, wptr_async,
      output rptr, raddr, empty, almost_empty, rlevel, underflow
   );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a Gray-coded pointer crossing clock domains.
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/rptr_empty.sv
// Read-domain pointer and status logic for the dual-clock FIFO: advances the
// read pointer and derives empty/almost_empty/level from the synchronized write pointer.
module rptr_empty
   import fifo_pkg::*;
#(
   parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
   parameter int AE_THRESH  = 1
) (
   input  logic       rclk,
   input  logic       rst,
   rptr_empty_if.slave bus
);

   localparam int PTR_W = ADDR_WIDTH + 1;

   logic [PTR_W-1:0]      wptrSync;
   logic [PTR_W-1:0]      wbinSync;
   logic                  accept;
   logic [PTR_W-1:0]      rbin_q,  rbin_d;
   logic [PTR_W-1:0]      rgray_q, rgray_d;
   logic [ADDR_WIDTH-1:0] raddr_q;
   logic [PTR_W-1:0]      level_d, level_q;
   logic                  empty_q, almostEmpty_q, underflow_q;

   sync_2ff #(.WIDTH(PTR_W)) uWptrSync (
      .clk_i (rclk),
      .rst_i (rst),
      .d_i   (bus.wptr_async),
      .q_o   (wptrSync)
   );

   // Read acceptance and a freshly synchronized write are folded into one edge.
   always_comb begin
      accept   = bus.rinc & ~empty_q;
      rbin_d   = rbin_q + PTR_W'(accept);
      rgray_d  = PTR_W'(bin2gray(32'(rbin_d)));
      wbinSync = PTR_W'(gray2bin(32'(wptrSync)));
      level_d  = wbinSync - rbin_d;
   end

   always_ff @(posedge rclk) begin
      if (rst) begin
         rbin_q        <= '0;
         rgray_q       <= '0;
         raddr_q       <= '0;
         level_q       <= '0;
         empty_q       <= 1'b1;
         almostEmpty_q <= 1'b1;
         underflow_q   <= 1'b0;
      end else begin
         rbin_q        <= rbin_d;
         rgray_q       <= rgray_d;
         raddr_q       <= rbin_d[ADDR_WIDTH-1:0];
         level_q       <= level_d;
         empty_q       <= (rgray_d == wptrSync);
         almostEmpty_q <= (level_d <= PTR_W'(AE_THRESH));
         underflow_q   <= underflow_q | (bus.rinc & empty_q);
      end
   end

   assign bus.rptr         = rgray_q;
   assign bus.raddr        = raddr_q;
   assign bus.empty        = empty_q;
   assign bus.almost_empty = almostEmpty_q;
   assign bus.rlevel       = level_q;
   assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_rptr_empty.sv
// Directed bench for rptr_empty: a counting model predicts each edge's outputs
// into a queue, which is drained and compared one entry per clock.
module tb_rptr_empty;

   localparam int AW = 3;
   localparam int PW = AW + 1;
   localparam int AE = 1;

   typedef struct {
      logic [PW-1:0] rptr;
      logic [AW-1:0] raddr;
      logic          empty;
      logic          ae;
      logic [PW-1:0] lvl;
      logic          uf;
   } exp_t;

   logic rclk = 1'b0;
   logic rst  = 1'b1;
   int   vecCount = 0;
   int   errCount = 0;
   exp_t expQ[$];

   logic [PW-1:0] mSync1, mSync2, mRcnt;
   logic          mEmpty, mUnder;
   logic [PW-1:0] wCnt;

   rptr_empty_if #(.ADDR_WIDTH(AW)) bus ();

   rptr_empty #(.ADDR_WIDTH(AW), .AE_THRESH(AE)) dut (
      .rclk (rclk),
      .rst  (rst),
      .bus  (bus.slave)
   );

   always #5 rclk = ~rclk;

   task automatic cmpField(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vecCount++;
      assert (obs === expv) else begin
         errCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic checkOutput();
      exp_t e;
      if (expQ.size() == 0) begin
         vecCount++;
         errCount++;
         $error("[TB] FAIL scoreboard observed=empty-queue expected=entry");
         return;
      end
      e = expQ.pop_front();
      cmpField("rptr",         32'(bus.rptr),         32'(e.rptr));
      cmpField("raddr",        32'(bus.raddr),        32'(e.raddr));
      cmpField("empty",        32'(bus.empty),        32'(e.empty));
      cmpField("almost_empty", 32'(bus.almost_empty), 32'(e.ae));
      cmpField("rlevel",       32'(bus.rlevel),       32'(e.lvl));
      cmpField("underflow",    32'(bus.underflow),    32'(e.uf));
   endtask

   // One rclk edge with the given inputs; the model predicts that edge's result.
   task automatic applyStimulus(input logic r, input logic resetIn);
      exp_t          e;
      logic          acc;
      logic [PW-1:0] rNext, lvl;
      rst            = resetIn;
      bus.rinc       = r;
      bus.wptr_async = wCnt ^ (wCnt >> 1);
      if (resetIn) begin
         mSync1 = '0;
         mSync2 = '0;
         mRcnt  = '0;
         mEmpty = 1'b1;
         mUnder = 1'b0;
         lvl    = '0;
      end else begin
         acc    = r & ~mEmpty;
         rNext  = mRcnt + PW'(acc);
         lvl    = mSync2 - rNext;
         mUnder = mUnder | (r & mEmpty);
         mSync2 = mSync1;
         mSync1 = wCnt;
         mRcnt  = rNext;
         mEmpty = (lvl == '0);
      end
      e.rptr  = mRcnt ^ (mRcnt >> 1);
      e.raddr = mRcnt[AW-1:0];
      e.empty = mEmpty;
      e.ae    = (lvl <= PW'(AE));
      e.lvl   = lvl;
      e.uf    = mUnder;
      expQ.push_back(e);
      @(posedge rclk);
      #1;
      checkOutput();
   endtask

   initial begin
      wCnt           = '0;
      bus.rinc       = 1'b0;
      bus.wptr_async = '0;

      // Reset and idle with nothing written
      applyStimulus(1'b0, 1'b1);
      applyStimulus(1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0);

      // Single write becomes visible on the third edge, then one read drains it
      wCnt = 4'd1;
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0);

      // Full FIFO drained by 8 back-to-back reads, then underflow on a ninth
      applyStimulus(1'b0, 1'b1);
      wCnt = 4'd8;
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0);
      for (int i = 0; i < 9; i++) applyStimulus(1'b1, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0);

      // Wrap: sixteen write/read pairs from a clean reset
      wCnt = '0;
      applyStimulus(1'b0, 1'b1);
      for (int n = 0; n < 16; n++) begin
         wCnt = wCnt + 1'b1;
         for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0);
         applyStimulus(1'b1, 1'b0);
      end
      applyStimulus(1'b0, 1'b0);

      // Reset while level is 5 and a read is requested
      wCnt = wCnt + 4'd5;
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0);
      bus.rinc = 1'b1;
      applyStimulus(1'b1, 1'b1);
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
      $finish;
   end

endmodule
